// File: rtl/mux_2_1_pkg.sv
// Shared constants and helpers for the 2:1 selector cell.
// Gate-level delay modelling is enabled by defining MUX_2_1_GATE_DELAY_EN.
`timescale 1ps/1ps

package mux_2_1_pkg;

    // Propagation delay of each datapath gate primitive when delays are modelled.
    localparam int MUX_GATE_DELAY = 50;

    // Default width of the select-toggle counter.
    localparam int MUX_CNT_W_DEFAULT = 16;

    // True only for a clean 0 or 1. Synthesis folds this to constant 1,
    // which makes the unknown-select flag a constant 0 in hardware.
    function automatic logic sel_is_known(input logic s);
        return (s === 1'b0) || (s === 1'b1);
    endfunction

endpackage

// File: rtl/mux_2_1_bit.sv
// Single-bit 2:1 gate cell: inverter, two 2-input ANDs and one 2-input OR.
// Each gate carries a MUX_GATE_DELAY delay when MUX_2_1_GATE_DELAY_EN is defined;
// otherwise the identical netlist is zero-delay.
`timescale 1ps/1ps

module mux_2_1_bit
    import mux_2_1_pkg::*;
(
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic out
);

    logic sel_n;
    logic and0;
    logic and1;

`ifdef MUX_2_1_GATE_DELAY_EN
    not #(MUX_GATE_DELAY) u_not  (sel_n, sel);
    and #(MUX_GATE_DELAY) u_and0 (and0, i0, sel_n);
    and #(MUX_GATE_DELAY) u_and1 (and1, i1, sel);
    or  #(MUX_GATE_DELAY) u_or   (out, and0, and1);
`else
    not u_not  (sel_n, sel);
    and u_and0 (and0, i0, sel_n);
    and u_and1 (and1, i1, sel);
    or  u_or   (out, and0, and1);
`endif

endmodule

// File: rtl/mux_2_1.sv
// WIDTH-bit 2:1 selector with a small clocked observability section that
// counts select changes (saturating) and flags an unknown select (sticky).
// The datapath is purely combinational and ignores clk and rst.
// Optional gate delays: define MUX_2_1_GATE_DELAY_EN (affects datapath only).
`timescale 1ps/1ps

module mux_2_1
    import mux_2_1_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = MUX_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] sel_toggles,
    output logic             sel_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Previously sampled select; only updated by a known select value.
    logic sel_q;

    // One gate cell per data bit, all sharing the select.
    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        mux_2_1_bit u_bit (
            .i0  (i0[n]),
            .i1  (i1[n]),
            .sel (sel),
            .out (out[n])
        );
    end

    // Count select changes (saturating) and latch any unknown select until reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= 1'b0;
            sel_toggles <= '0;
            sel_err     <= 1'b0;
        end else if (!sel_is_known(sel)) begin
            sel_err <= 1'b1;
        end else begin
            if ((sel != sel_q) && (sel_toggles != CNT_MAX)) begin
                sel_toggles <= sel_toggles + 1'b1;
            end
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux_2_1.sv
// Directed self-checking bench for mux_2_1: wide and single-bit select,
// toggle counting with async reset, counter saturation and unknown select.
`timescale 1ps/1ps

module tb_mux_2_1;
    import mux_2_1_pkg::*;

`ifdef MUX_2_1_GATE_DELAY_EN
    localparam int SETTLE = 3 * MUX_GATE_DELAY;
`else
    localparam int SETTLE = 1;
`endif

    logic clk = 1'b0;
    logic rst;

    // WIDTH=64 instance
    logic [63:0] w_i0, w_i1, w_out;
    logic        w_sel;
    logic [15:0] w_tog;
    logic        w_err;

    // WIDTH=1 instance with default counter
    logic        b_i0, b_i1, b_sel, b_out;
    logic [15:0] b_tog;
    logic        b_err;

    // WIDTH=1 instance with CNT_W=2
    logic        s_i0, s_i1, s_sel, s_out;
    logic [1:0]  s_tog;
    logic        s_err;

    int tests_run    = 0;
    int tests_failed = 0;
    logic four_state;

    always #500 clk = ~clk;

    mux_2_1 #(.WIDTH(64)) u_wide (
        .clk(clk), .rst(rst), .i0(w_i0), .i1(w_i1), .sel(w_sel),
        .out(w_out), .sel_toggles(w_tog), .sel_err(w_err)
    );

    mux_2_1 #(.WIDTH(1)) u_bit (
        .clk(clk), .rst(rst), .i0(b_i0), .i1(b_i1), .sel(b_sel),
        .out(b_out), .sel_toggles(b_tog), .sel_err(b_err)
    );

    mux_2_1 #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .i0(s_i0), .i1(s_i1), .sel(s_sel),
        .out(s_out), .sel_toggles(s_tog), .sel_err(s_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and sample 1 ps later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_sat;
        logic       probe;
        logic [4:0] pattern;

        probe = 1'bx;
        four_state = (probe === 1'bx);

        rst   = 1'b1;
        w_i0  = '0; w_i1 = '0; w_sel = 1'b0;
        b_i0  = 1'b0; b_i1 = 1'b0; b_sel = 1'b0;
        s_i0  = 1'b0; s_i1 = 1'b1; s_sel = 1'b0;
        #1;

        // Reset state
        check("rst_b_tog", 64'(b_tog), 64'd0);
        check("rst_b_err", 64'(b_err), 64'd0);
        check("rst_s_tog", 64'(s_tog), 64'd0);
        check("rst_w_tog", 64'(w_tog), 64'd0);
        check("rst_w_err", 64'(w_err), 64'd0);

        // Wide select both ways; reset is held high and must not force out
        w_i0  = 64'h0123_4567_89AB_CDEF;
        w_i1  = 64'hFFFF_0000_FFFF_0000;
        w_sel = 1'b0;
        #SETTLE;
        check("wide_sel0", w_out, 64'h0123_4567_89AB_CDEF);
        w_sel = 1'b1;
        #SETTLE;
        check("wide_sel1", w_out, 64'hFFFF_0000_FFFF_0000);
        #SETTLE;
        check("sat_out", 64'(s_out), 64'd0);

        // Single-bit truth table over {sel,i1,i0}
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = v[2:0];
            {b_sel, b_i1, b_i0} = vec;
            #SETTLE;
            check($sformatf("tt_%0d", v), 64'(b_out), 64'(vec[2] ? vec[1] : vec[0]));
            check($sformatf("tt_known_%0d", v), 64'($isunknown(b_out)), 64'd0);
        end

        // Toggle counting: release reset, sel 0,1,1,0,1 -> 3 toggles
        b_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pattern = 5'b10110;   // applied LSB first: 0,1,1,0,1
        for (int k = 0; k < 5; k++) begin
            b_sel = pattern[k];
            step();
        end
        check("tog_count", 64'(b_tog), 64'd3);

        // Async reset between edges clears before the next edge
        #100;
        rst = 1'b1;
        #1;
        check("tog_async_rst", 64'(b_tog), 64'd0);
        b_sel = 1'b0;
        step();
        b_sel = 1'b1;
        step();
        check("tog_hold_rst", 64'(b_tog), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation at CNT_W=2: six consecutive toggles stop at 3
        for (int k = 1; k <= 6; k++) begin
            s_sel = ~s_sel;
            step();
            exp_sat = (k < 3) ? 2'(k) : 2'd3;
            check($sformatf("sat_%0d", k), 64'(s_tog), 64'(exp_sat));
        end
        check("sat_err", 64'(s_err), 64'd0);

        // b_sel stayed 1 through those edges: one toggle from reset value 0
        check("pre_x_tog", 64'(b_tog), 64'd1);

        if (four_state) begin
            b_sel = 1'bx;
            step();
            check("x_err_set", 64'(b_err), 64'd1);
            check("x_tog_hold", 64'(b_tog), 64'd1);
            b_sel = 1'b1;
            step();
            check("x_err_sticky1", 64'(b_err), 64'd1);
            check("x_selq_kept", 64'(b_tog), 64'd1);
            b_sel = 1'b0;
            step();
            check("x_err_sticky2", 64'(b_err), 64'd1);
            check("x_tog_after", 64'(b_tog), 64'd2);
            #100;
            rst = 1'b1;
            #1;
            check("x_err_clear", 64'(b_err), 64'd0);
        end else begin
            check("err_clean", 64'(b_err), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
